mult_seq_stim: RTL and testbench
================================

// Module: mult_seq_stim
// PURPOSE
//  - Single-clock stimulus generator for multiclock assertion tests; drives a..f so that
//    the multiclock sequence/property under test passes or fails at a chosen step.
//  - Targets:
//    - mult_s = (@clk a) ##1 (@clk1 a##1b) ##1 (@clk2 c##1d), the sequence form.
//    - The mult_p8 else-branch form: @clk a##1b, c=0 & e, ##1 @clk2 f.
//  - Foreign clock edges arrive as one-cycle strobes tick1/tick2, sampled in clk.
//  - The block sits in the bench, upstream of the checker that holds the assertions.
// PARAMETERS
//  - NUM_RUNS  default 1  back-to-back sequences per start; 1..255.
//  - GAP       default 0  idle clk cycles between runs; 0..15.
// PORTS
//  - clk          in   1  system clock; all state on posedge.
//  - rst          in   1  asynchronous, active-high reset.
//  - tick1        in   1  one-cycle strobe = posedge clk1 seen in clk domain.
//  - tick2        in   1  one-cycle strobe = posedge clk2 seen in clk domain.
//  - start        in   1  request; accepted only when busy=0.
//  - mode         in   1  0 = mult_s, 1 = p8 else-branch; latched at start.
//  - inject       in   3  step to corrupt, 1..5; 0 = clean; latched at start.
//  - a,b,c,d,e,f  out  1  registered stimulus bits.
//  - busy         out  1  high from the accept cycle+1 until done.
//  - done         out  1  one-cycle pulse after the final step of the final run.
//  - err_injected out  1  copy of (inject!=0) for the current start; held until next start.
// BEHAVIOUR
//  - Reset (async): all outputs 0, state IDLE, run counter 0. A mid-run reset aborts
//    with no done pulse.
//  - States: IDLE, S1, S2, S3, S4, S5, GAPW, FIN.
//  - IDLE: start=1 -> S1 next edge; latch mode, inject and run count. start while busy
//    is ignored.
//  - Step outputs are registered on entry to a step and held until the next step;
//    the other bits are 0.
//  - mode 0 (mult_s):
//    - S1 drives a=1; advance on the next clk edge.
//    - S2 drives a=1; wait for tick1.
//    - S3 drives b=1; wait for tick1.
//    - S4 drives c=1; wait for tick2.
//    - S5 drives d=1; wait for tick2 -> GAPW or FIN.
//  - mode 1 (p8 else-branch):
//    - S1 drives a=1.
//    - S2 drives b=1; advance on clk.
//    - S3 drives c=0, e=1; advance on clk.
//    - S4 drives f=1; wait for tick2.
//    - S5 is skipped.
//  - Wait rule: a tick counts only if it occurs in a cycle where the state is waiting
//    on it. A tick in the entry cycle counts (strictly-later sampling is the bench's job).
//  - tick1 and tick2 in the same cycle: only the awaited strobe is consumed; the other
//    is dropped.
//  - inject=k: in step k the asserted bit is driven 0 instead of 1. Timing is unchanged.
//    k beyond the last step of the mode has no effect.
//  - Runs and completion:
//    - After the last step, run_cnt++.
//    - If run_cnt<NUM_RUNS: GAPW for GAP cycles with all bits 0, then S1. GAP=0 goes
//      directly to S1.
//    - Otherwise FIN: done=1 for one cycle, busy=0, then IDLE.
//  - Latency: start accept -> a=1 is 1 cycle. In mode 1, a clean run with tick2 present
//    is start..done = 5 cycles minimum.
//  - busy stays 1 through GAPW; done never overlaps a subsequent start accept.
// STRUCTURE
//  - Shared package mult_seq_pkg:
//    - typedef enum state_t.
//    - MODE_S=0, MODE_P8=1.
//    - STEP_* constants and the max step per mode.
//  - Single module; no sub-module. Step-to-bit mapping is a combinational case on
//    {mode,state}, registered at the outputs.
// TESTING
//  - Clean mode 0, tick1 every 3 cycles, tick2 every 5 -> a,a,b,c,d in order.
//    - Each step changes only on an awaited tick; done pulses once; err_injected=0.
//  - inject=3, mode 0 -> step S3 shows b=0 and all timing matches the clean run.
//    - The mult_s checker fails; err_injected=1.
//  - Mode 1, tick2 asserted in S4 entry cycle -> a,b,e,f on consecutive cycles, then
//    done.
//    - c=0 throughout.
//  - tick1 and tick2 both high every cycle, mode 0 -> each wait lasts exactly 1 cycle.
//    - No double advance.
//  - NUM_RUNS=3, GAP=2 -> three identical sequences separated by two all-zero cycles.
//    - busy=1 continuously; a single done pulse.
//  - rst pulsed during S4 -> all outputs 0 immediately, no done.
//    - A start after reset is accepted and runs clean.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multiclock-assertion stimulus generator.
// Step numbering, mode encoding and the step-to-bit pattern table live here.
package mult_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_S4   = 3'd4,
      ST_S5   = 3'd5,
      ST_GAPW = 3'd6,
      ST_FIN  = 3'd7
   } state_t;

   localparam logic MODE_S  = 1'b0;
   localparam logic MODE_P8 = 1'b1;

   localparam int unsigned STEP_W = 3;

   localparam logic [STEP_W-1:0] STEP_NONE = 3'd0;
   localparam logic [STEP_W-1:0] STEP_1    = 3'd1;
   localparam logic [STEP_W-1:0] STEP_2    = 3'd2;
   localparam logic [STEP_W-1:0] STEP_3    = 3'd3;
   localparam logic [STEP_W-1:0] STEP_4    = 3'd4;
   localparam logic [STEP_W-1:0] STEP_5    = 3'd5;

   localparam logic [STEP_W-1:0] MAX_STEP_S  = STEP_5;
   localparam logic [STEP_W-1:0] MAX_STEP_P8 = STEP_4;

   typedef struct packed {
      logic a;
      logic b;
      logic c;
      logic d;
      logic e;
      logic f;
   } stim_t;

   function automatic logic [STEP_W-1:0] step_of(input state_t s);
      case (s)
         ST_S1:   return STEP_1;
         ST_S2:   return STEP_2;
         ST_S3:   return STEP_3;
         ST_S4:   return STEP_4;
         ST_S5:   return STEP_5;
         default: return STEP_NONE;
      endcase
   endfunction

   function automatic logic [STEP_W-1:0] max_step(input logic mode);
      return (mode == MODE_P8) ? MAX_STEP_P8 : MAX_STEP_S;
   endfunction

   // Bits driven while in state s; the injected step has its asserted bit forced low.
   function automatic stim_t step_bits(input logic mode, input state_t s,
                                       input logic [STEP_W-1:0] inject);
      stim_t r;
      r = '0;
      case ({mode, s})
         {MODE_S,  ST_S1},
         {MODE_S,  ST_S2}: r.a = 1'b1;
         {MODE_S,  ST_S3}: r.b = 1'b1;
         {MODE_S,  ST_S4}: r.c = 1'b1;
         {MODE_S,  ST_S5}: r.d = 1'b1;
         {MODE_P8, ST_S1}: r.a = 1'b1;
         {MODE_P8, ST_S2}: r.b = 1'b1;
         {MODE_P8, ST_S3}: r.e = 1'b1;
         {MODE_P8, ST_S4}: r.f = 1'b1;
         default:          r = '0;
      endcase
      if (inject != STEP_NONE && inject == step_of(s) && inject <= max_step(mode))
         r = '0;
      return r;
   endfunction

endpackage

// File: rtl/mult_seq_stim.sv
// Stimulus generator for multiclock sequence/property checks: steps a..f through the
// mult_s or p8 else-branch pattern, advancing on clk or on foreign-clock tick strobes.
module mult_seq_stim
   import mult_seq_pkg::*;
#(
   parameter int unsigned NUM_RUNS = 1,
   parameter int unsigned GAP      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick1,
   input  logic              tick2,
   input  logic              start,
   input  logic              mode,
   input  logic [STEP_W-1:0] inject,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              d,
   output logic              e,
   output logic              f,
   output logic              busy,
   output logic              done,
   output logic              err_injected
);

   localparam int unsigned RUN_W = 8;
   localparam int unsigned GAP_W = 4;

   state_t              state;
   state_t              nxt_state;
   logic                mode_q;
   logic [STEP_W-1:0]   inject_q;
   logic [RUN_W-1:0]    run_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                last_step;
   logic                accept;
   logic                mode_eff;
   logic [STEP_W-1:0]   inject_eff;
   stim_t               nxt_bits;

   assign accept     = (state == ST_IDLE) && start;
   // On the accept edge the latched copies are not yet valid, so use the live inputs.
   assign mode_eff   = (state == ST_IDLE) ? mode   : mode_q;
   assign inject_eff = (state == ST_IDLE) ? inject : inject_q;

   // Next-state decode, including the end-of-run decision.
   always_comb begin
      nxt_state = state;
      last_step = 1'b0;
      case (state)
         ST_IDLE: if (start) nxt_state = ST_S1;
         ST_S1:   nxt_state = ST_S2;
         ST_S2:   if (mode_q == MODE_P8 || tick1) nxt_state = ST_S3;
         ST_S3:   if (mode_q == MODE_P8 || tick1) nxt_state = ST_S4;
         ST_S4: begin
            if (tick2) begin
               if (mode_q == MODE_P8) last_step = 1'b1;
               else                   nxt_state = ST_S5;
            end
         end
         ST_S5:   if (tick2) last_step = 1'b1;
         ST_GAPW: if (gap_cnt == '0) nxt_state = ST_S1;
         ST_FIN:  nxt_state = ST_IDLE;
         default: nxt_state = ST_IDLE;
      endcase
      if (last_step) begin
         if (({1'b0, run_cnt} + 9'd1) < 9'(NUM_RUNS))
            nxt_state = (GAP == 0) ? ST_S1 : ST_GAPW;
         else
            nxt_state = ST_FIN;
      end
   end

   assign nxt_bits = step_bits(mode_eff, nxt_state, inject_eff);

   // State, counters and all outputs are registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         mode_q       <= MODE_S;
         inject_q     <= STEP_NONE;
         run_cnt      <= '0;
         gap_cnt      <= '0;
         a            <= 1'b0;
         b            <= 1'b0;
         c            <= 1'b0;
         d            <= 1'b0;
         e            <= 1'b0;
         f            <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_injected <= 1'b0;
      end else begin
         state <= nxt_state;
         a     <= nxt_bits.a;
         b     <= nxt_bits.b;
         c     <= nxt_bits.c;
         d     <= nxt_bits.d;
         e     <= nxt_bits.e;
         f     <= nxt_bits.f;
         busy  <= (nxt_state != ST_IDLE) && (nxt_state != ST_FIN);
         done  <= (nxt_state == ST_FIN);

         if (accept) begin
            mode_q       <= mode;
            inject_q     <= inject;
            err_injected <= (inject != STEP_NONE);
            run_cnt      <= '0;
         end else if (last_step) begin
            run_cnt <= run_cnt + RUN_W'(1);
         end

         if (nxt_state == ST_GAPW && state != ST_GAPW)
            gap_cnt <= GAP_W'(GAP - 1);
         else if (state == ST_GAPW && gap_cnt != '0)
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

endmodule

// File: tb/tb_mult_seq_stim.sv
// Directed bench for mult_seq_stim: one default instance and one with three runs and a gap.
module tb_mult_seq_stim;

   logic       clk;
   logic       rst;
   logic       tick1;
   logic       tick2;
   logic       start;
   logic       start3;
   logic       mode;
   logic [2:0] inject;

   logic a, b, c, d, e, f, busy, done, err_injected;
   logic a3, b3, c3, d3, e3, f3, busy3, done3, err3;

   logic [7:0] o1;
   logic [7:0] o3;

   int n_cmp;
   int n_err;

   localparam logic [5:0] B0 = 6'b000000;
   localparam logic [5:0] BA = 6'b100000;
   localparam logic [5:0] BB = 6'b010000;
   localparam logic [5:0] BC = 6'b001000;
   localparam logic [5:0] BD = 6'b000100;
   localparam logic [5:0] BE = 6'b000010;
   localparam logic [5:0] BF = 6'b000001;

   assign o1 = {a, b, c, d, e, f, busy, done};
   assign o3 = {a3, b3, c3, d3, e3, f3, busy3, done3};

   mult_seq_stim dut (
      .clk(clk), .rst(rst), .tick1(tick1), .tick2(tick2), .start(start),
      .mode(mode), .inject(inject),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
      .busy(busy), .done(done), .err_injected(err_injected)
   );

   mult_seq_stim #(.NUM_RUNS(3), .GAP(2)) dut3 (
      .clk(clk), .rst(rst), .tick1(tick1), .tick2(tick2), .start(start3),
      .mode(mode), .inject(inject),
      .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3),
      .busy(busy3), .done(done3), .err_injected(err3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare {a..f,busy,done} of the chosen instance.
   task automatic cyc(input logic sel, input logic st, input logic t1, input logic t2,
                      input logic [5:0] eb, input logic eby, input logic ed, input string tag);
      if (sel) start3 = st; else start = st;
      tick1 = t1;
      tick2 = t2;
      @(posedge clk);
      #1;
      check(tag, sel ? o3 : o1, {eb, eby, ed});
   endtask

   function automatic logic [5:0] ex(input logic [2:0] inj, input logic [2:0] k,
                                     input logic [5:0] bits);
      return (inj == k) ? B0 : bits;
   endfunction

   // Mode 0 with sparse ticks; stray and simultaneous ticks must not advance the wrong wait.
   task automatic run_m0(input logic [2:0] inj, input string tag);
      mode = 1'b0;
      inject = inj;
      cyc(0, 1, 1, 0, ex(inj, 1, BA), 1, 0, {tag, "_s1"});
      cyc(0, 0, 0, 0, ex(inj, 2, BA), 1, 0, {tag, "_s2"});
      cyc(0, 0, 0, 0, ex(inj, 2, BA), 1, 0, {tag, "_s2_wait"});
      cyc(0, 0, 1, 0, ex(inj, 3, BB), 1, 0, {tag, "_s3"});
      cyc(0, 0, 0, 1, ex(inj, 3, BB), 1, 0, {tag, "_s3_t2_ignored"});
      cyc(0, 0, 1, 1, ex(inj, 4, BC), 1, 0, {tag, "_s4"});
      cyc(0, 0, 1, 0, ex(inj, 4, BC), 1, 0, {tag, "_s4_t1_ignored"});
      cyc(0, 0, 0, 1, ex(inj, 5, BD), 1, 0, {tag, "_s5"});
      cyc(0, 0, 1, 0, ex(inj, 5, BD), 1, 0, {tag, "_s5_wait"});
      cyc(0, 0, 0, 1, B0, 0, 1, {tag, "_done"});
      cyc(0, 0, 0, 0, B0, 0, 0, {tag, "_idle"});
      check({tag, "_err"}, {7'b0, err_injected}, {7'b0, inj != 3'd0});
   endtask

   // Mode 1; with late set, tick2 is pulsed only outside S4 first, then once inside it.
   task automatic run_m1(input logic [2:0] inj, input logic late, input string tag);
      mode = 1'b1;
      inject = inj;
      cyc(0, 1, 0, 0,    ex(inj, 1, BA), 1, 0, {tag, "_s1"});
      cyc(0, 0, 0, late, ex(inj, 2, BB), 1, 0, {tag, "_s2"});
      cyc(0, 0, 0, late, ex(inj, 3, BE), 1, 0, {tag, "_s3"});
      cyc(0, 0, 0, late, ex(inj, 4, BF), 1, 0, {tag, "_s4"});
      if (late) cyc(0, 0, 0, 0, ex(inj, 4, BF), 1, 0, {tag, "_s4_wait"});
      cyc(0, 0, 0, 1, B0, 0, 1, {tag, "_done"});
      cyc(0, 0, 0, 0, B0, 0, 0, {tag, "_idle"});
      check({tag, "_err"}, {7'b0, err_injected}, {7'b0, inj != 3'd0});
   endtask

   // Mode 0 with both ticks high every cycle: one cycle per step.
   task automatic run_both(input string tag);
      mode = 1'b0;
      inject = 3'd0;
      cyc(0, 1, 1, 1, BA, 1, 0, {tag, "_s1"});
      cyc(0, 0, 1, 1, BA, 1, 0, {tag, "_s2"});
      cyc(0, 0, 1, 1, BB, 1, 0, {tag, "_s3"});
      cyc(0, 0, 1, 1, BC, 1, 0, {tag, "_s4"});
      cyc(0, 0, 1, 1, BD, 1, 0, {tag, "_s5"});
      cyc(0, 0, 1, 1, B0, 0, 1, {tag, "_done"});
      cyc(0, 0, 0, 0, B0, 0, 0, {tag, "_idle"});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clk = 1'b0;
      rst = 1'b1;
      tick1 = 1'b0;
      tick2 = 1'b0;
      start = 1'b0;
      start3 = 1'b0;
      mode = 1'b0;
      inject = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_o1", o1, 8'h00);
      check("reset_o3", o3, 8'h00);
      check("reset_err", {7'b0, err_injected}, 8'h00);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_m0(3'd0, "m0_clean");
      run_m0(3'd3, "m0_inj3");
      run_m0(3'd5, "m0_inj5");
      run_m1(3'd0, 1'b0, "m1_clean");
      run_m1(3'd4, 1'b1, "m1_inj4_late");
      run_m1(3'd5, 1'b0, "m1_inj5_noeffect");
      run_both("both_ticks");
      check("err_cleared", {7'b0, err_injected}, 8'h00);

      // Three back-to-back runs separated by two idle cycles, busy held throughout.
      mode = 1'b0;
      inject = 3'd0;
      for (int r = 0; r < 3; r++) begin
         cyc(1, r == 0, 1, 1, BA, 1, 0, $sformatf("runs_r%0d_s1", r));
         cyc(1, 0, 1, 1, BA, 1, 0, $sformatf("runs_r%0d_s2", r));
         cyc(1, 0, 1, 1, BB, 1, 0, $sformatf("runs_r%0d_s3", r));
         cyc(1, 0, 1, 1, BC, 1, 0, $sformatf("runs_r%0d_s4", r));
         cyc(1, 0, 1, 1, BD, 1, 0, $sformatf("runs_r%0d_s5", r));
         if (r < 2) begin
            cyc(1, 0, 1, 1, B0, 1, 0, $sformatf("runs_r%0d_gap0", r));
            cyc(1, 0, 1, 1, B0, 1, 0, $sformatf("runs_r%0d_gap1", r));
         end
      end
      cyc(1, 0, 1, 1, B0, 0, 1, "runs_done");
      cyc(1, 0, 0, 0, B0, 0, 0, "runs_idle");
      check("runs_main_idle", o1, 8'h00);

      // Reset while in S4 clears everything at once and produces no done.
      mode = 1'b0;
      inject = 3'd0;
      cyc(0, 1, 0, 0, BA, 1, 0, "rst_s1");
      cyc(0, 0, 0, 0, BA, 1, 0, "rst_s2");
      cyc(0, 0, 1, 0, BB, 1, 0, "rst_s3");
      cyc(0, 0, 1, 0, BC, 1, 0, "rst_s4");
      tick1 = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_async_clear", o1, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(0, 0, 0, 1, B0, 0, 0, "rst_no_done0");
      cyc(0, 0, 0, 1, B0, 0, 0, "rst_no_done1");
      run_both("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
